axi4_ram_master: RTL and testbench
==================================

// Module: axi4_ram_master
// PURPOSE
// - Initiator for the simplified AXI4 RAM port used by the fivestage core. Turns single-beat core load/store requests into
//   the AW/W/B and AR/R sequences the RAM responder expects. Sits between the MEM stage and the RAM.
// - One transaction in flight; the core is stalled by io_req_ready until the current response has been returned.
// PARAMETERS
// - ADDR_W        32   address width
// - DATA_W        64   data width; strobe width is DATA_W/8
// - RD_LATENCY    1    cycles from the AR handshake to the cycle in which io_rdata is valid (1..15)
// - TIMEOUT_CYC   256  watchdog limit, used only when AXI_MASTER_TIMEOUT_EN is defined
// PORTS
// - clock          in   1        sole clock; all state changes on the rising edge
// - reset          in   1        synchronous, active-low: 0 at a rising clock edge resets the block
// - io_req_valid   in   1        core request valid
// - io_req_ready   out  1        block is idle and can accept a request
// - io_req_wen     in   1        1 = store, 0 = load
// - io_req_addr    in   ADDR_W   byte address
// - io_req_wdata   in   DATA_W   store data
// - io_req_wstrb   in   DATA_W/8 store byte enables
// - io_resp_valid  out  1        one-cycle pulse: transaction finished
// - io_resp_rdata  out  DATA_W   load data; held until the next load completes
// - io_resp_err    out  1        qualified by io_resp_valid; timeout flag
// - io_awaddr/io_awvalid out, io_awready in   write address channel
// - io_wdata/io_wstrb/io_wvalid out, io_wready in   write data channel
// - io_bvalid      in   1        write response; the RAM has no bready, so this pulse is consumed unconditionally
// - io_araddr/io_arvalid out, io_arready in   read address channel
// - io_rdata       in   DATA_W   read data; the RAM has no rvalid, so it is sampled by latency count
// BEHAVIOUR
// - Reset values: FSM=IDLE; io_req_ready=1; every *valid=0; all address/data/strobe outputs=0; io_resp_rdata=0; io_resp_err=0.
// - Acceptance: io_req_valid & io_req_ready registers addr, wdata, wstrb and wen. io_req_ready falls in the next cycle.
// - States and transitions:
//   - IDLE: accept a request -> WR when wen=1, RD_A when wen=0.
//   - RD_A: io_arvalid=1 and io_araddr=latched addr. On io_arready -> RD_W; arvalid falls next cycle. Counter cnt=RD_LATENCY.
//   - RD_W: decrement cnt each cycle. At cnt==1, capture io_rdata into io_resp_rdata -> RESP.
//     With RD_LATENCY=1, the data is captured in the cycle after the AR handshake.
//   - WR: io_awvalid and io_wvalid both asserted. Each channel drops independently on its own ready via flags aw_done and w_done.
//     When both flags are set -> WR_B. If both readies arrive in the same cycle, go straight to WR_B.
//   - WR_B: wait for io_bvalid -> RESP. A io_bvalid seen in any state other than WR_B is ignored.
//   - RESP: io_resp_valid=1 for exactly one cycle -> IDLE. io_req_ready=1 again from that next IDLE cycle.
// - Latency: a load with zero-wait ready takes 1 (RD_A) + RD_LATENCY + 1 (RESP) cycles from acceptance to resp_valid.
// - AXI rule: once a valid is asserted, it and its payload stay stable until the matching ready. Valid never depends on ready.
// - Stores leave io_resp_rdata unchanged.
// - A reset at any state aborts the transaction. Outputs return to reset values on that edge. No response is issued.
// CONFIGURATION
// - AXI_MASTER_TIMEOUT_EN defined: a 16-bit counter runs in RD_A, WR and WR_B. It clears on entry to each state.
//   - Reaching TIMEOUT_CYC forces RESP with io_resp_err=1 and deasserts all valids. A load that times out leaves io_resp_rdata unchanged.
// - Not defined: no counter. The block waits indefinitely, and io_resp_err is tied to 0.
// TESTING
// - Load, RD_LATENCY=1: addr 0x80000008, arready tied 1, io_rdata=0x1122334455667788 in the cycle after the AR handshake
//   -> resp_valid on acceptance+3 with rdata=0x1122334455667788 and err=0.
// - Store: addr 0x80000010, wdata 0xDEADBEEF, wstrb 0x0F. awready delayed 3 cycles, wready immediate, bvalid 2 cycles after both handshakes
//   -> wvalid drops after 1 cycle, awvalid after 4. Payload stays stable while waiting. One resp_valid pulse.
// - Back-to-back: io_req_valid held high for a store then a load -> the second request is accepted only in the IDLE cycle after the first RESP.
//   io_req_ready stays 0 throughout the first transaction.
// - Stray io_bvalid pulse during RD_W -> ignored. The read completes normally and the FSM does not enter or leave a write state.
// - Reset driven to 0 in WR_B for one cycle -> all valids are 0 next cycle, io_req_ready=1, and no resp_valid pulse.
// - AXI_MASTER_TIMEOUT_EN, TIMEOUT_CYC=8, arready never asserted -> resp_valid with err=1 at acceptance+10, arvalid=0 afterwards.

Source files
------------

// File: rtl/axi4_ram_master.sv
// Single-outstanding AXI4 initiator that turns core load/store requests into AR/R or AW/W/B sequences.
// Optional watchdog: define AXI_MASTER_TIMEOUT_EN to abort stalled transactions with io_resp_err=1.
module axi4_ram_master #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int RD_LATENCY  = 1,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_req_valid,
  output logic                io_req_ready,
  input  logic                io_req_wen,
  input  logic [ADDR_W-1:0]   io_req_addr,
  input  logic [DATA_W-1:0]   io_req_wdata,
  input  logic [DATA_W/8-1:0] io_req_wstrb,
  output logic                io_resp_valid,
  output logic [DATA_W-1:0]   io_resp_rdata,
  output logic                io_resp_err,
  output logic [ADDR_W-1:0]   io_awaddr,
  output logic                io_awvalid,
  input  logic                io_awready,
  output logic [DATA_W-1:0]   io_wdata,
  output logic [DATA_W/8-1:0] io_wstrb,
  output logic                io_wvalid,
  input  logic                io_wready,
  input  logic                io_bvalid,
  output logic [ADDR_W-1:0]   io_araddr,
  output logic                io_arvalid,
  input  logic                io_arready,
  input  logic [DATA_W-1:0]   io_rdata
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_W = 3'd2,
    WR   = 3'd3,
    WR_B = 3'd4,
    RESP = 3'd5
  } state_e;

  state_e              state_r, state_s;
  logic                req_ready_r, req_ready_s;
  logic                awvalid_r, awvalid_s, wvalid_r, wvalid_s, arvalid_r, arvalid_s;
  logic [ADDR_W-1:0]   awaddr_r, awaddr_s, araddr_r, araddr_s;
  logic [DATA_W-1:0]   wdata_r, wdata_s, resp_rdata_r, resp_rdata_s;
  logic [STRB_W-1:0]   wstrb_r, wstrb_s;
  logic                aw_done_r, aw_done_s, w_done_r, w_done_s;
  logic [3:0]          cnt_r, cnt_s;
  logic                resp_valid_r, resp_valid_s, resp_err_r, resp_err_s;
  logic                aw_fire_s, w_fire_s, timeout_s;

  assign aw_fire_s = awvalid_r & io_awready;
  assign w_fire_s  = wvalid_r & io_wready;

`ifdef AXI_MASTER_TIMEOUT_EN
  logic [15:0] tcnt_r, tcnt_s;

  assign timeout_s = (tcnt_r == 16'(TIMEOUT_CYC));

  // Watchdog count: restarts on every state change, runs only while waiting on the RAM
  always_comb begin
    tcnt_s = 16'd0;
    if (state_s != state_r) begin
      tcnt_s = 16'd0;
    end else if ((state_r == RD_A) || (state_r == WR) || (state_r == WR_B)) begin
      tcnt_s = tcnt_r + 16'd1;
    end else begin
      tcnt_s = 16'd0;
    end
  end

  // Watchdog register
  always_ff @(posedge clock) begin
    if (!reset) begin
      tcnt_r <= 16'd0;
    end else begin
      tcnt_r <= tcnt_s;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and next-output logic; every output is registered from these values
  always_comb begin
    state_s      = state_r;
    req_ready_s  = req_ready_r;
    awvalid_s    = awvalid_r;
    wvalid_s     = wvalid_r;
    arvalid_s    = arvalid_r;
    awaddr_s     = awaddr_r;
    araddr_s     = araddr_r;
    wdata_s      = wdata_r;
    wstrb_s      = wstrb_r;
    aw_done_s    = aw_done_r;
    w_done_s     = w_done_r;
    cnt_s        = cnt_r;
    resp_rdata_s = resp_rdata_r;
    resp_valid_s = 1'b0;
    resp_err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (io_req_valid && req_ready_r) begin
          req_ready_s = 1'b0;
          if (io_req_wen) begin
            state_s   = WR;
            awvalid_s = 1'b1;
            wvalid_s  = 1'b1;
            awaddr_s  = io_req_addr;
            wdata_s   = io_req_wdata;
            wstrb_s   = io_req_wstrb;
            aw_done_s = 1'b0;
            w_done_s  = 1'b0;
          end else begin
            state_s   = RD_A;
            arvalid_s = 1'b1;
            araddr_s  = io_req_addr;
          end
        end else begin
          req_ready_s = 1'b1;
        end
      end
      RD_A: begin
        if (io_arready) begin
          arvalid_s = 1'b0;
          cnt_s     = 4'(RD_LATENCY);
          state_s   = RD_W;
        end else if (timeout_s) begin
          arvalid_s    = 1'b0;
          resp_valid_s = 1'b1;
          resp_err_s   = 1'b1;
          state_s      = RESP;
        end else begin
          state_s = RD_A;
        end
      end
      RD_W: begin
        // RAM has no rvalid: data is taken purely by latency count
        if (cnt_r == 4'd1) begin
          resp_rdata_s = io_rdata;
          resp_valid_s = 1'b1;
          state_s      = RESP;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      WR: begin
        aw_done_s = aw_done_r | aw_fire_s;
        w_done_s  = w_done_r | w_fire_s;
        awvalid_s = awvalid_r & ~aw_fire_s;
        wvalid_s  = wvalid_r & ~w_fire_s;
        if (aw_done_s && w_done_s) begin
          state_s = WR_B;
        end else if (timeout_s) begin
          awvalid_s    = 1'b0;
          wvalid_s     = 1'b0;
          resp_valid_s = 1'b1;
          resp_err_s   = 1'b1;
          state_s      = RESP;
        end else begin
          state_s = WR;
        end
      end
      WR_B: begin
        if (io_bvalid) begin
          resp_valid_s = 1'b1;
          state_s      = RESP;
        end else if (timeout_s) begin
          resp_valid_s = 1'b1;
          resp_err_s   = 1'b1;
          state_s      = RESP;
        end else begin
          state_s = WR_B;
        end
      end
      RESP: begin
        state_s     = IDLE;
        req_ready_s = 1'b1;
      end
      default: begin
        state_s     = IDLE;
        req_ready_s = 1'b1;
        awvalid_s   = 1'b0;
        wvalid_s    = 1'b0;
        arvalid_s   = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r      <= IDLE;
      req_ready_r  <= 1'b1;
      awvalid_r    <= 1'b0;
      wvalid_r     <= 1'b0;
      arvalid_r    <= 1'b0;
      awaddr_r     <= {ADDR_W{1'b0}};
      araddr_r     <= {ADDR_W{1'b0}};
      wdata_r      <= {DATA_W{1'b0}};
      wstrb_r      <= {STRB_W{1'b0}};
      aw_done_r    <= 1'b0;
      w_done_r     <= 1'b0;
      cnt_r        <= 4'd0;
      resp_rdata_r <= {DATA_W{1'b0}};
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      req_ready_r  <= req_ready_s;
      awvalid_r    <= awvalid_s;
      wvalid_r     <= wvalid_s;
      arvalid_r    <= arvalid_s;
      awaddr_r     <= awaddr_s;
      araddr_r     <= araddr_s;
      wdata_r      <= wdata_s;
      wstrb_r      <= wstrb_s;
      aw_done_r    <= aw_done_s;
      w_done_r     <= w_done_s;
      cnt_r        <= cnt_s;
      resp_rdata_r <= resp_rdata_s;
      resp_valid_r <= resp_valid_s;
      resp_err_r   <= resp_err_s;
    end
  end

  assign io_req_ready  = req_ready_r;
  assign io_resp_valid = resp_valid_r;
  assign io_resp_rdata = resp_rdata_r;
  assign io_resp_err   = resp_err_r;
  assign io_awaddr     = awaddr_r;
  assign io_awvalid    = awvalid_r;
  assign io_wdata      = wdata_r;
  assign io_wstrb      = wstrb_r;
  assign io_wvalid     = wvalid_r;
  assign io_araddr     = araddr_r;
  assign io_arvalid    = arvalid_r;

endmodule

// File: tb/tb_axi4_ram_master.sv
// Directed + randomized bench for axi4_ram_master: the bench acts as the RAM responder and keeps
// an independent memory model updated from the core's requests.
module tb_axi4_ram_master;
  localparam int RD_LAT = 1;
  localparam int TO_CYC = 8;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_req_valid = 1'b0, io_req_ready, io_req_wen = 1'b0;
  logic [31:0] io_req_addr = 32'd0;
  logic [63:0] io_req_wdata = 64'd0;
  logic [7:0]  io_req_wstrb = 8'd0;
  logic        io_resp_valid, io_resp_err;
  logic [63:0] io_resp_rdata;
  logic [31:0] io_awaddr, io_araddr;
  logic        io_awvalid, io_wvalid, io_arvalid;
  logic        io_awready = 1'b0, io_wready = 1'b0, io_bvalid = 1'b0, io_arready = 1'b0;
  logic [63:0] io_wdata, io_rdata = 64'd0;
  logic [7:0]  io_wstrb;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] ram   [8];
  logic [63:0] model [8];
  logic [63:0] last_rdata;

  axi4_ram_master #(.ADDR_W(32), .DATA_W(64), .RD_LATENCY(RD_LAT), .TIMEOUT_CYC(TO_CYC)) dut (
    .clock(clock), .reset(reset),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready), .io_req_wen(io_req_wen),
    .io_req_addr(io_req_addr), .io_req_wdata(io_req_wdata), .io_req_wstrb(io_req_wstrb),
    .io_resp_valid(io_resp_valid), .io_resp_rdata(io_resp_rdata), .io_resp_err(io_resp_err),
    .io_awaddr(io_awaddr), .io_awvalid(io_awvalid), .io_awready(io_awready),
    .io_wdata(io_wdata), .io_wstrb(io_wstrb), .io_wvalid(io_wvalid), .io_wready(io_wready),
    .io_bvalid(io_bvalid), .io_araddr(io_araddr), .io_arvalid(io_arvalid),
    .io_arready(io_arready), .io_rdata(io_rdata)
  );

  // 10-time-unit clock; the bench samples and drives on the falling edge
  always #5 clock = ~clock;

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] data, input logic [7:0] strb);
    logic [63:0] res;
    res = old;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    check(tag, 64'(obs), 64'(exp));
  endtask

  task automatic check_reset_vals(input string tag);
    check1({tag, "_req_ready"}, io_req_ready, 1'b1);
    check({tag, "_valids"}, 64'({io_awvalid, io_wvalid, io_arvalid, io_resp_valid, io_resp_err}), 64'd0);
    check({tag, "_addrs"}, {io_awaddr, io_araddr}, 64'd0);
    check({tag, "_wdata"}, io_wdata, 64'd0);
    check({tag, "_wstrb"}, 64'(io_wstrb), 64'd0);
    check({tag, "_rdata"}, io_resp_rdata, 64'd0);
  endtask

  // Load: AR handshake after ar_d wait cycles; RAM data driven only in the latency cycle.
  task automatic do_load(input int idx, input int ar_d, input bit stray_b);
    logic [31:0] addr;
    logic [63:0] exp;
    int          hs;
    int          hs_idx;
    bit          done;
    addr   = BASE + 32'(idx * 8);
    exp    = model[idx];
    hs     = -1;
    hs_idx = 0;
    done   = 1'b0;
    check1("ld_ready_at_accept", io_req_ready, 1'b1);
    io_req_valid = 1'b1; io_req_wen = 1'b0; io_req_addr = addr;
    io_req_wdata = {$urandom, $urandom}; io_req_wstrb = 8'($urandom);
    @(negedge clock);
    io_req_valid = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      check1("ld_req_ready_low", io_req_ready, 1'b0);
      check("ld_no_write", 64'({io_awvalid, io_wvalid}), 64'd0);
      io_arready = 1'b0; io_bvalid = 1'b0; io_rdata = {$urandom, $urandom};
      if (hs < 0) begin
        check1("ld_arvalid", io_arvalid, 1'b1);
        check("ld_araddr", 64'(io_araddr), 64'(addr));
        check1("ld_resp_early", io_resp_valid, 1'b0);
        if (c - 1 >= ar_d) begin
          io_arready = 1'b1;
          hs         = c;
          hs_idx     = int'(io_araddr[5:3]);
        end
      end else begin
        check1("ld_arvalid_low", io_arvalid, 1'b0);
        if (c == hs + RD_LAT) io_rdata = ram[hs_idx];
        if (stray_b && c == hs + 1) io_bvalid = 1'b1;
        if (c == hs + RD_LAT + 1) begin
          check1("ld_resp_valid", io_resp_valid, 1'b1);
          check("ld_rdata", io_resp_rdata, exp);
          check1("ld_err", io_resp_err, 1'b0);
          done = 1'b1;
        end else begin
          check1("ld_resp_early", io_resp_valid, 1'b0);
        end
      end
      @(negedge clock);
    end
    check1("ld_completed", done, 1'b1);
    io_arready = 1'b0; io_bvalid = 1'b0;
    last_rdata = exp;
    check1("ld_idle_ready", io_req_ready, 1'b1);
    check1("ld_single_pulse", io_resp_valid, 1'b0);
    check("ld_rdata_held", io_resp_rdata, last_rdata);
  endtask

  // Store: AW ready from cycle 1+aw_d, W ready from 1+w_d, bvalid b_d cycles after the later one.
  task automatic do_store(input int idx, input logic [63:0] data, input logic [7:0] strb,
                          input int aw_d, input int w_d, input int b_d,
                          input bit stray_b, input bit b2b, input int nxt_idx);
    logic [31:0] addr;
    logic [63:0] cap_data;
    logic [7:0]  cap_strb;
    int          aw_idx, both, bc;
    bit          done;
    addr     = BASE + 32'(idx * 8);
    both     = 1 + ((aw_d > w_d) ? aw_d : w_d);
    bc       = both + b_d;
    done     = 1'b0;
    aw_idx   = 0;
    cap_data = 64'd0;
    cap_strb = 8'd0;
    check1("st_ready_at_accept", io_req_ready, 1'b1);
    io_req_valid = 1'b1; io_req_wen = 1'b1; io_req_addr = addr;
    io_req_wdata = data; io_req_wstrb = strb;
    @(negedge clock);
    if (b2b) begin
      io_req_valid = 1'b1; io_req_wen = 1'b0; io_req_addr = BASE + 32'(nxt_idx * 8);
    end else begin
      io_req_valid = 1'b0;
    end
    for (int c = 1; c <= 60 && !done; c++) begin
      check1("st_req_ready_low", io_req_ready, 1'b0);
      check1("st_no_ar", io_arvalid, 1'b0);
      check1("st_awvalid", io_awvalid, c <= 1 + aw_d);
      check1("st_wvalid", io_wvalid, c <= 1 + w_d);
      if (c <= 1 + aw_d) check("st_awaddr", 64'(io_awaddr), 64'(addr));
      if (c <= 1 + w_d) begin
        check("st_wdata", io_wdata, data);
        check("st_wstrb", 64'(io_wstrb), 64'(strb));
      end
      io_awready = (c >= 1 + aw_d);
      io_wready  = (c >= 1 + w_d);
      io_bvalid  = (c == bc) || (stray_b && c == 1);
      if (c == 1 + aw_d) aw_idx = int'(io_awaddr[5:3]);
      if (c == 1 + w_d) begin
        cap_data = io_wdata;
        cap_strb = io_wstrb;
      end
      if (c == both) ram[aw_idx] = merge(ram[aw_idx], cap_data, cap_strb);
      if (c == bc + 1) begin
        check1("st_resp_valid", io_resp_valid, 1'b1);
        check1("st_err", io_resp_err, 1'b0);
        done = 1'b1;
      end else begin
        check1("st_resp_early", io_resp_valid, 1'b0);
      end
      @(negedge clock);
    end
    check1("st_completed", done, 1'b1);
    io_awready = 1'b0; io_wready = 1'b0; io_bvalid = 1'b0;
    model[idx] = merge(model[idx], data, strb);
    check1("st_idle_ready", io_req_ready, 1'b1);
    check1("st_single_pulse", io_resp_valid, 1'b0);
    check("st_rdata_unchanged", io_resp_rdata, last_rdata);
  endtask

  initial begin
    int          idx, ad, wd, bd;
    bit          sb;
    logic [63:0] d;
    logic [7:0]  s;
    for (int i = 0; i < 8; i++) begin
      d        = {$urandom, $urandom};
      ram[i]   = d;
      model[i] = d;
    end
    ram[1]     = 64'h1122_3344_5566_7788;
    model[1]   = 64'h1122_3344_5566_7788;
    last_rdata = 64'd0;

    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_vals("rst");
    reset = 1'b1;
    @(negedge clock);

    // Directed load at 0x80000008, arready immediate
    do_load(1, 0, 1'b0);
    // Directed store at 0x80000010: awready delayed 3, wready immediate, bvalid 2 after
    do_store(2, 64'h0000_0000_DEAD_BEEF, 8'h0F, 3, 0, 2, 1'b0, 1'b0, 0);
    do_load(2, 1, 1'b0);
    // Back-to-back: store with req_valid held, then the queued load
    do_store(4, 64'hA5A5_5A5A_0102_0304, 8'hF0, 1, 2, 1, 1'b0, 1'b1, 4);
    do_load(4, 0, 1'b0);
    // Stray bvalid during the read wait
    do_load(3, 2, 1'b1);

    // Reset while waiting in WR_B
    check1("rwb_ready", io_req_ready, 1'b1);
    io_req_valid = 1'b1; io_req_wen = 1'b1; io_req_addr = BASE + 32'd24;
    io_req_wdata = 64'h0BAD_F00D_CAFE_0001; io_req_wstrb = 8'hFF;
    @(negedge clock);
    io_req_valid = 1'b0; io_awready = 1'b1; io_wready = 1'b1;
    check1("rwb_awvalid", io_awvalid, 1'b1);
    check1("rwb_wvalid", io_wvalid, 1'b1);
    @(negedge clock);
    io_awready = 1'b0; io_wready = 1'b0;
    check("rwb_in_wrb", 64'({io_awvalid, io_wvalid, io_resp_valid, io_req_ready}), 64'd0);
    ram[3]   = merge(ram[3], 64'h0BAD_F00D_CAFE_0001, 8'hFF);
    model[3] = merge(model[3], 64'h0BAD_F00D_CAFE_0001, 8'hFF);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check_reset_vals("rwb_after");
    last_rdata = 64'd0;
    io_bvalid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      io_bvalid = 1'b0;
      check1("rwb_no_resp", io_resp_valid, 1'b0);
      check1("rwb_ready_kept", io_req_ready, 1'b1);
    end

    // Randomized mix against the memory model
    for (int t = 0; t < 30; t++) begin
      idx = int'($urandom_range(0, 7));
      ad  = int'($urandom_range(0, 3));
      wd  = int'($urandom_range(0, 3));
      bd  = int'($urandom_range(1, 3));
      sb  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) begin
        do_load(idx, ad, sb);
      end else begin
        d = {$urandom, $urandom};
        s = 8'($urandom);
        do_store(idx, d, s, ad, wd, bd, sb, 1'b0, 0);
      end
    end

`ifdef AXI_MASTER_TIMEOUT_EN
    // Watchdog: arready never comes, response with err at acceptance+10
    check1("to_ready", io_req_ready, 1'b1);
    io_req_valid = 1'b1; io_req_wen = 1'b0; io_req_addr = BASE;
    @(negedge clock);
    io_req_valid = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      check1("to_arvalid", io_arvalid, c <= 9);
      check1("to_resp_valid", io_resp_valid, c == 10);
      if (c == 10) check1("to_err", io_resp_err, 1'b1);
      check("to_rdata_held", io_resp_rdata, last_rdata);
      @(negedge clock);
    end
    check1("to_idle_ready", io_req_ready, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
